dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single byte-wide data memory (Mem) between two requesters: the pipeline MEM stage (port P, load/store of S-slot) and a loader/debug port (port L) that preloads or inspects data memory.
- Sits between pipeline2 outputs and Mem. It drives the memory control and address, routes the returned byte to its owner and produces p_stall for the hazard unit (gates PC and pipeline-register write enables).
- Arbitration is pipeline-priority with a starvation guard, plus a bounded loader burst lock.

Parameters:
- ADDR_W, 32, address width of both ports and of Mem.
- DATA_W, 8, data width (Mem is byte-wide).
- MAX_WAIT, 4, consecutive denied loader cycles before the loader is forced a grant.
- MAX_BURST, 8, maximum consecutive loader grants under l_lock before a forced release.

Ports:
- clk in 1: rising-edge clock.
- reset in 1: synchronous, active-high.
- p_req in 1: pipeline access request (p2_memRead | p2_memWrite).
- p_we in 1: 1 = store, 0 = load.
- p_addr in ADDR_W: pipeline address.
- p_wdata in DATA_W: store byte.
- p_stall out 1: pipeline request not granted this cycle.
- p_rvalid out 1: pipeline load data valid.
- p_rdata out DATA_W: pipeline load data.
- l_req in 1: loader request.
- l_we in 1: loader store when 1.
- l_lock in 1: loader requests burst ownership.
- l_addr in ADDR_W: loader address.
- l_wdata in DATA_W: loader store byte.
- l_gnt out 1: loader access accepted this cycle.
- l_rvalid out 1: loader load data valid.
- l_rdata out DATA_W: loader load data.
- mem_read out 1: Mem read enable.
- mem_write out 1: Mem write enable.
- mem_addr out ADDR_W: Mem address.
- mem_wdata out DATA_W: Mem write data.
- mem_rdata in DATA_W: Mem read data, valid 1 cycle after mem_read.

Behaviour:
- Memory accepts one access per cycle. Read latency is 1 (data on mem_rdata in the cycle after mem_read=1).
- Grant is combinational from the current state and requests. Exactly one of grant_P or grant_L per cycle, or none.
- FSM states:
  - IDLE:
    - If cnt_wait==MAX_WAIT and l_req: grant L.
    - Else if p_req: grant P.
    - Else if l_req: grant L.
    - Move to LBURST when L is granted with l_lock=1.
  - LBURST:
    - Grant L while l_req & l_lock and burst_cnt<MAX_BURST.
    - Return to IDLE when l_lock=0, l_req=0, or burst_cnt==MAX_BURST.
    - In the cycle burst_cnt==MAX_BURST, grant P if p_req, else grant L if l_req (without lock).
    - burst_cnt clears on exit.
- Memory drive:
  - mem_read = grant & ~we.
  - mem_write = grant & we.
  - mem_addr and mem_wdata come from the granted port.
  - With no grant, mem_read=mem_write=0 and mem_addr/mem_wdata=0.
- Outputs:
  - p_stall = p_req & ~grant_P.
  - l_gnt = grant_L.
- cnt_wait:
  - Increments (saturating at MAX_WAIT) each cycle l_req=1 and grant_L=0.
  - Clears on grant_L or l_req=0.
- Read return tag register {valid, owner}:
  - Written each cycle with {mem_read, owner}.
  - Next cycle: the owner's rvalid=1 and its rdata=mem_rdata. The other port's rvalid=0, rdata holds its last value.
- Simultaneous p_req and l_req in IDLE with cnt_wait<MAX_WAIT: P wins, L waits.
- Load then store back-to-back from different ports is legal. The tag ensures the returning byte goes to the original requester.
- Reset (any cycle, including with a read outstanding):
  - Next state IDLE; cnt_wait=0, burst_cnt=0, tag valid=0.
  - p_rvalid=l_rvalid=0, p_rdata=l_rdata=0.
  - The in-flight read result is discarded.
  - While reset=1, all grants are forced 0 (mem_read=mem_write=0, p_stall=0, l_gnt=0).
- Address wrap: none. Addresses pass through unchanged.

Decomposition:
- Shared package (dmem_pkg): FSM state encoding (IDLE=1'b0, LBURST=1'b1), owner encoding (OWN_P=0, OWN_L=1), default ADDR_W/DATA_W constants.
- One natural sub-module: dmem_rd_tag, the 1-cycle return tag register and rdata demux.

Test Plan:
1. Reset mid-read:
   - P load addr 0x10 in cycle n, reset=1 in cycle n+1.
   - Required: p_rvalid=0 at n+1 and n+2, p_rdata=0, FSM IDLE.
2. Contention:
   - p_req & l_req held for 6 cycles, MAX_WAIT=4.
   - Required: P granted cycles 0-3 (p_stall=0), L granted cycle 4 (p_stall=1, l_gnt=1), P granted cycle 5.
3. Load routing:
   - Mem preloaded 0x20=0xA5, 0x21=0x3C. P reads 0x20 in cycle n, L reads 0x21 in cycle n+1.
   - Required: p_rvalid=1/p_rdata=0xA5 at n+1; l_rvalid=1/l_rdata=0x3C at n+2; l_rvalid=0 at n+1.
4. Burst lock:
   - l_lock=1, l_req=1 for 12 cycles, p_req=1 from cycle 2, MAX_BURST=8.
   - Required: l_gnt=1 cycles 0-7, p_stall=1 cycles 2-7, grant P at cycle 8, L resumes after.
5. Store path:
   - L writes 0x5A to 0x40, then P loads 0x40.
   - Required: mem_write=1, mem_addr=0x40, mem_wdata=0x5A in the write cycle; p_rdata=0x5A one cycle after the P load grant.
6. Idle:
   - No requests for 5 cycles.
   - Required: mem_read=mem_write=0, mem_addr=0, p_stall=0, l_gnt=0, both rvalid=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: arbitration state,
// read-return owner encoding and default widths/limits.
package dmem_pkg;

  // Default address and data widths (Mem is byte-wide).
  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DATA_W_DEF    = 8;

  // Default fairness limits for the loader port.
  localparam int unsigned MAX_WAIT_DEF  = 4;
  localparam int unsigned MAX_BURST_DEF = 8;

  // Arbitration state: normal pipeline-priority mode or loader burst ownership.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LBURST = 1'b1
  } arb_state_e;

  // Which requester a returning read byte belongs to.
  typedef enum logic {
    OWN_P = 1'b0,
    OWN_L = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_rd_tag.sv
// One-cycle read-return tag: remembers who issued the read and steers the
// returning Mem byte to that port, holding each port's last returned byte.
module dmem_rd_tag
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_issue,
  input  owner_e            rd_owner,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata
);

  logic              tag_valid_q, tag_valid_d;
  owner_e            tag_owner_q, tag_owner_d;
  logic [DATA_W-1:0] p_hold_q, p_hold_d;
  logic [DATA_W-1:0] l_hold_q, l_hold_d;

  // Demux the returning byte; reset suppresses any in-flight result at once.
  always_comb begin
    tag_valid_d = rd_issue;
    tag_owner_d = rd_owner;
    p_rvalid    = tag_valid_q && (tag_owner_q == OWN_P) && !reset;
    l_rvalid    = tag_valid_q && (tag_owner_q == OWN_L) && !reset;
    p_hold_d    = p_rvalid ? mem_rdata : p_hold_q;
    l_hold_d    = l_rvalid ? mem_rdata : l_hold_q;
    p_rdata     = reset ? '0 : p_hold_d;
    l_rdata     = reset ? '0 : l_hold_d;
  end

  // Tag and per-port hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_q <= 1'b0;
      tag_owner_q <= OWN_P;
      p_hold_q    <= '0;
      l_hold_q    <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
      p_hold_q    <= p_hold_d;
      l_hold_q    <= l_hold_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the byte-wide data memory between the pipeline MEM stage
// (port P) and the loader/debug port (port L). Pipeline has priority, the
// loader is protected from starvation and may hold a bounded locked burst.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic [WAIT_W-1:0]  cnt_wait_q, cnt_wait_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               grant_p, grant_l;
  logic               rd_issue;
  owner_e             rd_owner;

  // Grant decision and next arbitration state from current state and requests.
  always_comb begin
    grant_p     = 1'b0;
    grant_l     = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (l_req && (cnt_wait_q == WAIT_MAX)) begin
          grant_l = 1'b1;
        end else if (p_req) begin
          grant_p = 1'b1;
        end else if (l_req) begin
          grant_l = 1'b1;
        end
        if (grant_l && l_lock) begin
          state_d     = ST_LBURST;
          burst_cnt_d = BURST_W'(1);
        end
      end
      ST_LBURST: begin
        if (l_req && l_lock && (burst_cnt_q < BURST_MAX)) begin
          grant_l     = 1'b1;
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end else begin
          state_d     = ST_IDLE;
          burst_cnt_d = '0;
          if (p_req) begin
            grant_p = 1'b1;
          end else if (l_req) begin
            grant_l = 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
    if (reset) begin
      grant_p = 1'b0;
      grant_l = 1'b0;
    end
  end

  // Loader starvation counter: counts consecutive denied loader cycles.
  always_comb begin
    cnt_wait_d = '0;
    if (l_req && !grant_l) begin
      cnt_wait_d = (cnt_wait_q == WAIT_MAX) ? cnt_wait_q : cnt_wait_q + WAIT_W'(1);
    end
  end

  // Drive Mem from the granted port; everything is zero when nobody is granted.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_p) begin
      mem_read  = !p_we;
      mem_write = p_we;
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end else if (grant_l) begin
      mem_read  = !l_we;
      mem_write = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
    rd_issue = mem_read;
    rd_owner = grant_l ? OWN_L : OWN_P;
    p_stall  = p_req && !grant_p && !reset;
    l_gnt    = grant_l;
  end

  // Arbitration state and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_wait_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_wait_q  <= cnt_wait_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  dmem_rd_tag #(
    .DATA_W(DATA_W)
  ) u_rd_tag (
    .clk      (clk),
    .reset    (reset),
    .rd_issue (rd_issue),
    .rd_owner (rd_owner),
    .mem_rdata(mem_rdata),
    .p_rvalid (p_rvalid),
    .p_rdata  (p_rdata),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata)
  );

endmodule
